// File: rtl/vram_arbiter.sv
// Single-port VRAM arbiter: display row refresh, full-screen clear and
// pixel read-modify-write share one synchronous-read RAM, one operation at a time.
module vram_arbiter #(
    parameter logic FILL = 1'b0
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic [4:0]  disp_address_i,
    output logic [63:0] disp_data_o,
    input  logic        wr_req_i,
    input  logic [5:0]  wr_x_i,
    input  logic [4:0]  wr_y_i,
    input  logic        wr_value_i,
    output logic        wr_ack_o,
    input  logic        clr_req_i,
    output logic        clr_ack_o,
    output logic [4:0]  ram_addr_o,
    input  logic [63:0] ram_rdata_i,
    output logic [63:0] ram_wdata_o,
    output logic        ram_we_o
);

    typedef enum logic [2:0] {
        StIdle,
        StDispRd,
        StDispCap,
        StPixRd,
        StPixWr,
        StClr
    } state_e;

    state_e      state_q, state_d;
    logic [63:0] disp_data_q, disp_data_d;
    logic [4:0]  cap_addr_q, cap_addr_d;
    logic [4:0]  clr_cnt_q, clr_cnt_d;
    logic        disp_pending_q, disp_pending_d;
    logic        disp_need;

    // Address change is seen directly so an idle arbiter starts the refresh on the next edge.
    assign disp_need = disp_pending_q | (disp_address_i != cap_addr_q);

    always_comb begin
        state_d     = state_q;
        disp_data_d = disp_data_q;
        cap_addr_d  = cap_addr_q;
        clr_cnt_d   = clr_cnt_q;
        ram_addr_o  = '0;
        ram_wdata_o = '0;
        ram_we_o    = 1'b0;
        wr_ack_o    = 1'b0;
        clr_ack_o   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (disp_need) begin
                    state_d = StDispRd;
                end else if (clr_req_i) begin
                    state_d = StClr;
                end else if (wr_req_i) begin
                    state_d = StPixRd;
                end
            end
            StDispRd: begin
                ram_addr_o = disp_address_i;
                cap_addr_d = disp_address_i;
                state_d    = StDispCap;
            end
            StDispCap: begin
                disp_data_d = ram_rdata_i;
                state_d     = StIdle;
            end
            StPixRd: begin
                ram_addr_o = wr_y_i;
                state_d    = StPixWr;
            end
            StPixWr: begin
                ram_addr_o          = wr_y_i;
                ram_wdata_o         = ram_rdata_i;
                ram_wdata_o[wr_x_i] = wr_value_i;
                ram_we_o            = 1'b1;
                wr_ack_o            = 1'b1;
                state_d             = StIdle;
            end
            StClr: begin
                ram_addr_o  = clr_cnt_q;
                ram_wdata_o = {64{FILL}};
                ram_we_o    = 1'b1;
                if (clr_cnt_q == 5'd31) begin
                    clr_ack_o = 1'b1;
                    clr_cnt_d = 5'd0;
                    state_d   = StIdle;
                end else begin
                    clr_cnt_d = clr_cnt_q + 5'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        disp_pending_d = disp_pending_q | (disp_address_i != cap_addr_d);
        if ((state_q == StPixWr) && (wr_y_i == cap_addr_q)) begin
            disp_pending_d = 1'b1;
        end
        if ((state_q == StClr) && (clr_cnt_q == cap_addr_q)) begin
            disp_pending_d = 1'b1;
        end
        if (state_d == StDispRd) begin
            disp_pending_d = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q        <= StIdle;
            disp_data_q    <= '0;
            cap_addr_q     <= '0;
            clr_cnt_q      <= '0;
            disp_pending_q <= 1'b1;
        end else begin
            state_q        <= state_d;
            disp_data_q    <= disp_data_d;
            cap_addr_q     <= cap_addr_d;
            clr_cnt_q      <= clr_cnt_d;
            disp_pending_q <= disp_pending_d;
        end
    end

    assign disp_data_o = disp_data_q;

endmodule

// File: doc/vram_arbiter.md
VRAM_ARBITER -- requirements
Module: vram_arbiter

Interface
REQ-001 Parameter FILL, default 1'b0: bit value written to every VRAM bit by a clear operation.
REQ-002 clock  in  1  system clock; all state changes on posedge.
REQ-003 reset  in  1  asynchronous, active-low reset; one clock domain, no other reset.
REQ-004 disp_address  in  5  row requested by display driver (0..31).
REQ-005 disp_data  out  64  latched contents of row disp_address; bit n = pixel column n.
REQ-006 wr_req  in  1  pixel write request, level; wr_x/wr_y/wr_value held stable until wr_ack.
REQ-007 wr_x  in  6  pixel column (bit index 0..63).
REQ-008 wr_y  in  5  pixel row (0..31).
REQ-009 wr_value  in  1  new pixel value.
REQ-010 wr_ack  out  1  one-cycle pulse: pixel write committed.
REQ-011 clr_req  in  1  full-screen clear request, level; held until clr_ack.
REQ-012 clr_ack  out  1  one-cycle pulse: clear finished.
REQ-013 ram_addr  out  5  VRAM row address.
REQ-014 ram_rdata  in  64  VRAM read data, valid one clock after ram_addr presented (synchronous read).
REQ-015 ram_wdata  out  64  VRAM write data.
REQ-016 ram_we  out  1  VRAM write enable, write on posedge when high.

Function
REQ-017 Single-port VRAM shared between display refresh, clear and pixel read-modify-write; exactly one operation in flight.
REQ-018 States: IDLE, DISP_RD, DISP_CAP, PIX_RD, PIX_WR, CLR.
REQ-019 disp_pending flag set when disp_address differs from last captured row address, or when a write/clear touches the captured row; cleared on entering DISP_RD.
REQ-020 IDLE priority: disp_pending -> DISP_RD; else clr_req -> CLR; else wr_req -> PIX_RD; else stay.
REQ-021 DISP_RD: ram_addr = disp_address (sampled into capture-address register), ram_we=0; next DISP_CAP.
REQ-022 DISP_CAP: disp_data <= ram_rdata; next IDLE; disp_data changes only here.
REQ-023 PIX_RD: ram_addr = wr_y, ram_we=0; next PIX_WR.
REQ-024 PIX_WR: ram_addr = wr_y, ram_wdata = ram_rdata with bit wr_x replaced by wr_value, ram_we=1, wr_ack=1; next IDLE.
REQ-025 CLR: row counter 0..31, one row per cycle, ram_wdata = {64{FILL}}, ram_we=1; after row 31 written clr_ack=1 in that same cycle, counter wraps to 0, next IDLE.
REQ-026 Write/clear in progress not pre-empted by display; address change during it only sets disp_pending.
REQ-027 Uncontended pixel write: wr_req seen in IDLE at edge N -> ram_we and wr_ack high in cycle N+2.
REQ-028 disp_data reflects a new disp_address within 3 clocks if arbiter idle, within 35 clocks worst case (clear in progress).
REQ-029 wr_req and clr_req together: clear first; pixel write afterwards onto cleared image.
REQ-030 wr_ack/clr_ack never high outside PIX_WR / final CLR cycle; ram_we low in all other states.
REQ-031 wr_req still high in cycle after wr_ack is a new request (requester must drop it).

Reset
REQ-032 reset low: state IDLE, disp_data=0, wr_ack=0, clr_ack=0, ram_we=0, ram_addr=0, ram_wdata=0, clear counter=0, capture-address=0.
REQ-033 disp_pending=1 at reset release; first operation is a refresh read of disp_address.
REQ-034 reset mid-write or mid-clear aborts immediately; no further ram_we pulse; no ack issued for aborted operation.

Verification
REQ-035 Reset release, RAM row 0 = 64'hA5A5_0000_FFFF_1234, disp_address=0 -> ram_addr=0 in DISP_RD, disp_data=64'hA5A5_0000_FFFF_1234 after DISP_CAP.
REQ-036 Row 3 = 0, wr_x=63, wr_y=3, wr_value=1 -> ram_we one cycle with ram_wdata=64'h8000_0000_0000_0000, wr_ack coincident, 2 cycles after IDLE sample.
REQ-037 disp_address=3 captured, write bit 0 of row 3 -> disp_pending set, disp_data later = old row | 1.
REQ-038 clr_req and wr_req same cycle, FILL=0 -> 32 consecutive ram_we cycles rows 0..31, clr_ack on row 31, then pixel RMW; row holds only the written bit.
REQ-039 reset low during CLR at row 10 -> ram_we drops at once, no clr_ack; after release, refresh read precedes clear restart.
